seq_divider: RTL and testbench



---
 rtl/seq_divider_pkg.sv | 15 +
 rtl/seq_divider_div_step.sv | 22 ++
 rtl/seq_divider.sv | 125 ++++++++++++
 tb/tb_seq_divider.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the iterative restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  localparam int unsigned DefaultWidth = 16;

  // Divide-by-zero quotient (all ones); sliced to WIDTH, so WIDTH must not exceed 64.
  localparam logic [63:0] DbzQuotAll = '1;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_in_i,
  input  logic             dvd_msb_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_out_o,
  output logic             q_bit_o
);

  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] trial;

  always_comb begin
    rem_sh    = {rem_in_i, dvd_msb_i};
    trial     = rem_sh - {2'b00, dvs_i};
    q_bit_o   = ~trial[WIDTH+1];
    rem_out_o = q_bit_o ? trial[WIDTH:0] : rem_sh[WIDTH:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, signed/unsigned per transaction, valid/ready on both sides.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             signed_mode_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_by_zero_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_e           state_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             q_neg_q, r_neg_q, zdiv_q;
  logic             out_valid_q, dbz_q;
  logic [WIDTH-1:0] quotient_q, remainder_q;

  logic [WIDTH:0]   step_rem;
  logic             step_q_bit;
  logic             dvd_sign, dvs_sign;
  logic [WIDTH-1:0] dvd_mag, dvs_mag, q_fin, r_fin;

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .rem_in_i (rem_q),
    .dvd_msb_i(dvd_q[WIDTH-1]),
    .dvs_i    (dvs_q),
    .rem_out_o(step_rem),
    .q_bit_o  (step_q_bit)
  );

  always_comb begin
    dvd_sign = signed_mode_i & dividend_i[WIDTH-1];
    dvs_sign = signed_mode_i & divisor_i[WIDTH-1];
    dvd_mag  = dvd_sign ? -dividend_i : dividend_i;
    dvs_mag  = dvs_sign ? -divisor_i : divisor_i;
    q_fin    = q_neg_q ? -dvd_q : dvd_q;
    r_fin    = r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      zdiv_q      <= 1'b0;
      out_valid_q <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid_i) begin
            dvs_q <= dvs_mag;
            if (divisor_i == '0) begin
              // Preload the final values and skip the iterations; only the finalise step runs.
              dvd_q   <= DbzQuotAll[WIDTH-1:0];
              rem_q   <= {1'b0, dividend_i};
              q_neg_q <= 1'b0;
              r_neg_q <= 1'b0;
              cnt_q   <= CNT_W'(WIDTH);
              zdiv_q  <= 1'b1;
            end else begin
              dvd_q   <= dvd_mag;
              rem_q   <= '0;
              q_neg_q <= dvd_sign ^ dvs_sign;
              r_neg_q <= dvd_sign;
              cnt_q   <= '0;
              zdiv_q  <= 1'b0;
            end
            state_q <= StCalc;
          end
        end
        StCalc: begin
          // WIDTH shift/subtract edges, then one edge to sign-correct and register the result.
          if (cnt_q == CNT_W'(WIDTH)) begin
            quotient_q  <= q_fin;
            remainder_q <= r_fin;
            dbz_q       <= zdiv_q;
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            rem_q <= step_rem;
            dvd_q <= {dvd_q[WIDTH-2:0], step_q_bit};
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready_o    = (state_q == StIdle);
  assign out_valid_o   = out_valid_q;
  assign quotient_o    = quotient_q;
  assign remainder_o   = remainder_q;
  assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus random operands against an arithmetic model.
module tb_seq_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         signed_mode = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(
    .WIDTH(W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .signed_mode_i(signed_mode),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .quotient_o   (quotient),
    .remainder_o  (remainder),
    .div_by_zero_o(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: C-style truncating division; zero divisor gives all-ones / raw dividend.
  function automatic void model(input bit sm, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    int sa, sb, ua, ub;
    if (b == 0) begin
      q = 16'hFFFF;
      r = a;
      z = 1'b1;
    end else if (sm) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
      z  = 1'b0;
    end else begin
      ua = int'({16'h0000, a});
      ub = int'({16'h0000, b});
      q  = W'(ua / ub);
      r  = W'(ua % ub);
      z  = 1'b0;
    end
  endfunction

  task automatic run_txn(input bit sm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int stall);
    logic [W-1:0] eq, er, hq, hr;
    logic         ez;
    int           lat, exp_lat;
    model(sm, a, b, eq, er, ez);
    exp_lat = (b == 0) ? 1 : W + 1;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid    = 1'b1;
    signed_mode = sm;
    dividend    = a;
    divisor     = b;
    out_ready   = (stall == 0);
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    signed_mode = 1'($urandom);
    dividend    = W'($urandom);
    divisor     = W'($urandom);
    check("in_ready_busy", 32'(in_ready), 32'd0);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 200);
    check("latency", 32'(lat), 32'(exp_lat));
    check("quotient", 32'(quotient), 32'(eq));
    check("remainder", 32'(remainder), 32'(er));
    check("div_by_zero", 32'(div_by_zero), 32'(ez));
    if (stall > 0) begin
      hq = quotient;
      hr = remainder;
      in_valid = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(posedge clk);
        #1;
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_quot", 32'(quotient), 32'(eq));
        check("hold_rem", 32'(remainder), 32'(er));
        check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("valid_drop", 32'(out_valid), 32'd0);
    check("ready_back", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quot", 32'(quotient), 32'd0);
    check("rst_rem", 32'(remainder), 32'd0);
    check("rst_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(1'b0, 16'd1000, 16'd7, 0);
    run_txn(1'b1, 16'hFC18, 16'h0007, 0);
    run_txn(1'b1, 16'd7, 16'hFFFE, 0);
    run_txn(1'b0, 16'h1234, 16'h0000, 0);
    run_txn(1'b1, 16'h8765, 16'h0000, 0);
    run_txn(1'b1, 16'h8000, 16'hFFFF, 0);
    run_txn(1'b0, 16'hFFFF, 16'h0001, 0);
    run_txn(1'b0, 16'd12345, 16'd99, 10);

    // Asynchronous reset after 8 iteration steps drops the transaction.
    @(negedge clk);
    in_valid  = 1'b1;
    dividend  = 16'd1000;
    divisor   = 16'd7;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_quot", 32'(quotient), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b0, 16'd100, 16'd10, 0);

    for (int n = 0; n < 24; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1, 2:    rb = W'($urandom_range(1, 15));
        3:       rb = 16'hFFFF;
        default: rb = W'($urandom);
      endcase
      run_txn(1'($urandom), ra, rb, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
